// File: rtl/gcd_lcm_coproc.sv
// gcd_lcm_coproc: memory-mapped GCD/LCM coprocessor (subtractive Euclid, restoring divide, shift-add multiply)
// Optional registered irq output is enabled by defining GCD_LCM_IRQ_EN.
module gcd_lcm_coproc #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        busy,
`ifdef GCD_LCM_IRQ_EN
  output logic        irq,
`endif
  output logic        done
);
  localparam int W  = WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [2:0] {S_IDLE, S_GCD, S_DIV, S_MUL, S_DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, q_q, q_d;
  logic [2*W-1:0] p_q, p_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, done_q, done_d, ovr_q, ovr_d;
  logic start_wr, g_exit, zero_op, last, div_ge;
  logic [W-1:0] g, div_sub, div_rem;
  logic [W:0] div_tmp;
  logic [2*W-1:0] mul_sum;

  assign busy     = !(state_q == S_IDLE || state_q == S_DONE);
  assign done     = done_q;
  assign start_wr = sel && we && addr[3:2] == 2'd0 && wd[2*W];
  assign zero_op  = a_q == '0 || b_q == '0;
  assign g_exit   = zero_op || a_q == b_q;
  assign g        = a_q | b_q;
  assign last     = cnt_q == CW'(W - 1);
  // During DIV, a holds the gcd divisor, b the partial remainder, q shifts dividend out and quotient in
  assign div_tmp  = {b_q, q_q[W-1]};
  assign div_ge   = div_tmp >= {1'b0, a_q};
  assign div_sub  = div_tmp[W-1:0] - a_q;
  assign div_rem  = div_ge ? div_sub : div_tmp[W-1:0];
  // During MUL, q is the multiplier consumed LSB first; y is added at weight 2^cnt
  assign mul_sum  = q_q[0] ? p_q + ({{W{1'b0}}, y_q} << cnt_q) : p_q;
`ifdef GCD_LCM_IRQ_EN
  // done is itself a register that sets on entering DONE and clears on accepted start or reset
  assign irq = done_q;
`endif
  assign rd = !sel ? '0 :
              addr[3:2] == 2'd1 ? {29'b0, ovr_q, done_q, busy} :
              addr[3:2] == 2'd2 ? {{(32-2*W){1'b0}}, res_q} : '0;

  // Next-state logic: command acceptance, overrun flagging and the GCD/DIV/MUL sequence
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    q_d     = q_q;
    p_d     = p_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = done_q;
    ovr_d   = ovr_q || (start_wr && busy);
    case (state_q)
      S_IDLE, S_DONE: if (start_wr) begin
        state_d = S_GCD;
        x_d     = wd[W-1:0];
        y_d     = wd[2*W-1:W];
        a_d     = wd[W-1:0];
        b_d     = wd[2*W-1:W];
        op_d    = wd[2*W+1];
        done_d  = 1'b0;
        ovr_d   = 1'b0;
      end
      S_GCD: if (g_exit) begin
        if (op_q && !zero_op) begin
          state_d = S_DIV;
          q_d     = x_q;
          b_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_DONE;
          res_d   = op_q ? '0 : {{W{1'b0}}, g};
          done_d  = 1'b1;
        end
      end else if (a_q > b_q) a_d = a_q - b_q;
      else b_d = b_q - a_q;
      S_DIV: begin
        b_d   = div_rem;
        q_d   = {q_q[W-2:0], div_ge};
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          state_d = S_MUL;
          p_d     = '0;
        end
      end
      S_MUL: begin
        p_d   = mul_sum;
        q_d   = q_q >> 1;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          res_d   = mul_sum;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      q_q     <= q_d;
      p_q     <= p_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// tb_gcd_lcm_coproc: table-driven, randomized and hand-sequenced checks of the GCD/LCM coprocessor
module tb_gcd_lcm_coproc;
  logic        clk = 1'b0, reset = 1'b0, sel = 1'b0, we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wd = '0, rd;
  logic        busy, done;
`ifdef GCD_LCM_IRQ_EN
  logic        irq;
`endif
  int pass = 0, total = 0;

  typedef struct {
    bit    op;
    int    x;
    int    y;
    int    res;
    int    cyc;
    string name;
  } vec_t;
  vec_t tv[8];

  always #5 clk = ~clk;

  gcd_lcm_coproc #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wd(wd), .rd(rd), .busy(busy),
`ifdef GCD_LCM_IRQ_EN
    .irq(irq),
`endif
    .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = '0; wd = '0;
  endtask

  task automatic cmd(input bit op, input bit start, input logic [7:0] y, input logic [7:0] x);
    wr(4'h0, {14'b0, op, start, y, x});
  endtask

  task automatic rdreg(input logic [1:0] r, output logic [31:0] v);
    sel = 1'b1; we = 1'b0; addr = {r, 2'b00};
    #1 v = rd;
    sel = 1'b0; addr = '0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Reference: Euclid by division; subtractive step count is the sum of quotients
  function automatic void ref_model(input bit op, input int x, input int y, output int res, output int cyc);
    int a, b, t, g, s;
    a = x; b = y; s = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
      cyc = 1;
    end else begin
      while (b != 0) begin
        s += a / b;
        t = a % b;
        a = b;
        b = t;
      end
      g = a;
      cyc = s;
    end
    if (!op) res = g;
    else if (x == 0 || y == 0) res = 0;
    else begin
      res = (x / g) * y;
      cyc += 16;
    end
  endfunction

  task automatic run_vec(input bit op, input int x, input int y, input int res, input int cyc, input string name);
    int c;
    logic [31:0] v;
    cmd(op, 1'b1, 8'(y), 8'(x));
    wait_idle(c);
    chk({name, " cycles"}, c, cyc);
    rdreg(2'd1, v);
    chk({name, " status"}, v, 32'h2);
    rdreg(2'd2, v);
    chk({name, " result"}, v, res);
`ifdef GCD_LCM_IRQ_EN
    chk({name, " irq"}, {31'b0, irq}, 32'h1);
`endif
  endtask

  initial begin
    logic [31:0] v;
    int c, er, ec;
    bit rop;
    int rx, ry;
    tv[0] = '{0, 12, 18, 6, 3, "gcd12_18"};
    tv[1] = '{1, 12, 18, 36, 19, "lcm12_18"};
    tv[2] = '{1, 255, 254, 64770, 271, "lcm255_254"};
    tv[3] = '{0, 0, 9, 9, 1, "gcd0_9"};
    tv[4] = '{1, 0, 9, 0, 1, "lcm0_9"};
    tv[5] = '{0, 0, 0, 0, 1, "gcd0_0"};
    tv[6] = '{1, 7, 7, 7, 17, "lcm7_7"};
    tv[7] = '{0, 255, 1, 1, 255, "gcd255_1"};
    repeat (2) @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'h0);
    rdreg(2'd1, v);
    chk("rst status", v, 32'h0);
    rdreg(2'd2, v);
    chk("rst result", v, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(tv[i].op, tv[i].x, tv[i].y, tv[i].res, tv[i].cyc, tv[i].name);
    for (int i = 0; i < 20; i++) begin
      rop = 1'($urandom_range(0, 1));
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 255));
      ref_model(rop, rx, ry, er, ec);
      run_vec(rop, rx, ry, er, ec, $sformatf("rnd%0d", i));
    end
    cmd(1'b0, 1'b1, 8'd1, 8'd255);
    repeat (9) @(negedge clk);
    cmd(1'b0, 1'b1, 8'd18, 8'd12);
    rdreg(2'd1, v);
    chk("ovr set", v, 32'h5);
    wait_idle(c);
    chk("ovr idle", {31'b0, busy}, 32'h0);
    rdreg(2'd2, v);
    chk("ovr result", v, 32'h1);
    rdreg(2'd1, v);
    chk("ovr done status", v, 32'h6);
    cmd(1'b0, 1'b1, 8'd18, 8'd12);
    rdreg(2'd1, v);
    chk("ovr cleared", v, 32'h1);
`ifdef GCD_LCM_IRQ_EN
    chk("irq cleared", {31'b0, irq}, 32'h0);
`endif
    wait_idle(c);
    rdreg(2'd2, v);
    chk("post ovr result", v, 32'h6);
    wr(4'h0, {14'b0, 1'b1, 1'b0, 8'd9, 8'd0});
    @(negedge clk);
    rdreg(2'd1, v);
    chk("start0 status", v, 32'h2);
    rdreg(2'd2, v);
    chk("start0 result", v, 32'h6);
    wr(4'h8, 32'hFFFF_FFFF);
    wr(4'h4, 32'hFFFF_FFFF);
    rdreg(2'd2, v);
    chk("reswr result", v, 32'h6);
    rdreg(2'd1, v);
    chk("reswr status", v, 32'h2);
`ifdef GCD_LCM_IRQ_EN
    chk("irq held", {31'b0, irq}, 32'h1);
`endif
    cmd(1'b0, 1'b1, 8'd1, 8'd255);
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'h0);
    chk("midrst done", {31'b0, done}, 32'h0);
    rdreg(2'd2, v);
    chk("midrst result", v, 32'h0);
    rdreg(2'd1, v);
    chk("midrst status", v, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rdreg(2'd1, v);
    chk("after rst idle", v, 32'h0);
    run_vec(1'b0, 12, 18, 6, 3, "after rst gcd");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
